// File: rtl/rram_train_ctrl.sv
// Drive sequencer for the RRAM crossbar: row-by-row SET initialisation and
// forward/back training pulses per sample, with registered line enables.
module rram_train_ctrl #(
    parameter int N_ROWS    = 6,
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 2,
    parameter int TRAIN_NUM = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set,
    input  logic              learn,
    input  logic              sample_valid,
    input  logic [N_ROWS-1:0] sample_x,
    input  logic              sample_label,
    output logic              sample_ready,
    output logic [N_ROWS-1:0] Dwl,
    output logic [N_ROWS-1:0] Dsl,
    output logic [N_ROWS-1:0] Dbl,
    output logic              Dset,
    output logic              Dback,
    output logic              Dlabel,
    output logic              busy,
    output logic              done,
    output logic [7:0]        sample_cnt
);

    // state     | meaning
    // IDLE      | waiting for set/learn command
    // SET_PULSE | SET pulse on current row (word line + all bit lines)
    // SET_GAP   | all lines low between SET rows
    // WAIT_S    | sample_ready high, waiting for a sample transfer
    // FWD       | forward/read pulse of latched sample
    // BACK      | back/update pulse of latched sample
    // GAP       | all lines low after a pulse pair
    // FIN       | one-cycle done, back to IDLE

    localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int TW = 16;
    localparam logic [TW-1:0]     P_LD     = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0]     G_LD     = TW'(GAP_CYC - 1);
    localparam logic [RW-1:0]     ROW_LAST = RW'(N_ROWS - 1);
    localparam logic [7:0]        CNT_END  = 8'(TRAIN_NUM);
    localparam logic [N_ROWS-1:0] ONES     = '1;
    localparam logic [N_ROWS-1:0] ONE      = N_ROWS'(1);

    typedef enum logic [2:0] {
        IDLE, SET_PULSE, SET_GAP, WAIT_S, FWD, BACK, GAP, FIN
    } state_t;

    state_t            state, state_nx;
    logic [TW-1:0]     timer, timer_nx;
    logic [RW-1:0]     row, row_nx;
    logic [N_ROWS-1:0] x_q, x_nx;
    logic              label_q, label_nx;
    logic [7:0]        cnt_nx;

    logic [N_ROWS-1:0] dwl_nx, dsl_nx, dbl_nx;
    logic              dset_nx, dback_nx, dlabel_nx, busy_nx, done_nx, ready_nx;

    always_comb begin
        state_nx = state;
        timer_nx = (timer != '0) ? timer - 1'b1 : '0;
        row_nx   = row;
        x_nx     = x_q;
        label_nx = label_q;
        cnt_nx   = sample_cnt;
        case (state)
            IDLE: begin
                if (set) begin
                    state_nx = SET_PULSE;
                    row_nx   = '0;
                    timer_nx = P_LD;
                end else if (learn) begin
                    state_nx = WAIT_S;
                    cnt_nx   = '0;
                end
            end
            SET_PULSE: begin
                if (timer == '0) begin
                    state_nx = SET_GAP;
                    timer_nx = G_LD;
                end
            end
            SET_GAP: begin
                if (timer == '0) begin
                    if (row == ROW_LAST) begin
                        state_nx = FIN;
                    end else begin
                        state_nx = SET_PULSE;
                        row_nx   = row + 1'b1;
                        timer_nx = P_LD;
                    end
                end
            end
            WAIT_S: begin
                if (sample_valid) begin
                    state_nx = FWD;
                    x_nx     = sample_x;
                    label_nx = sample_label;
                    timer_nx = P_LD;
                end
            end
            FWD: begin
                if (timer == '0) begin
                    state_nx = BACK;
                    timer_nx = P_LD;
                end
            end
            BACK: begin
                if (timer == '0) begin
                    state_nx = GAP;
                    timer_nx = G_LD;
                    cnt_nx   = sample_cnt + 8'd1;
                end
            end
            GAP: begin
                if (timer == '0) state_nx = (sample_cnt == CNT_END) ? FIN : WAIT_S;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decode the next state so the registered drives line up with the state.
    always_comb begin
        dwl_nx    = '0;
        dsl_nx    = '0;
        dbl_nx    = '0;
        dset_nx   = 1'b0;
        dback_nx  = 1'b0;
        dlabel_nx = 1'b0;
        ready_nx  = 1'b0;
        done_nx   = 1'b0;
        busy_nx   = (state_nx != IDLE) && (state_nx != FIN);
        case (state_nx)
            SET_PULSE: begin
                dwl_nx  = ONE << row_nx;
                dbl_nx  = ONES;
                dset_nx = 1'b1;
            end
            WAIT_S: ready_nx = 1'b1;
            FWD: begin
                dwl_nx    = x_nx;
                dsl_nx    = ONES;
                dlabel_nx = label_nx;
            end
            BACK: begin
                dwl_nx   = x_nx;
                dbl_nx   = label_nx ? x_nx : ~x_nx;
                dback_nx = 1'b1;
            end
            FIN:     done_nx = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            timer        <= '0;
            row          <= '0;
            x_q          <= '0;
            label_q      <= 1'b0;
            sample_cnt   <= '0;
            Dwl          <= '0;
            Dsl          <= '0;
            Dbl          <= '0;
            Dset         <= 1'b0;
            Dback        <= 1'b0;
            Dlabel       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sample_ready <= 1'b0;
        end else begin
            state        <= state_nx;
            timer        <= timer_nx;
            row          <= row_nx;
            x_q          <= x_nx;
            label_q      <= label_nx;
            sample_cnt   <= cnt_nx;
            Dwl          <= dwl_nx;
            Dsl          <= dsl_nx;
            Dbl          <= dbl_nx;
            Dset         <= dset_nx;
            Dback        <= dback_nx;
            Dlabel       <= dlabel_nx;
            busy         <= busy_nx;
            done         <= done_nx;
            sample_ready <= ready_nx;
        end
    end

endmodule

// File: tb/tb_rram_train_ctrl.sv
// Bench for rram_train_ctrl: a frame-schedule model predicts every cycle's
// outputs from command/sample events; directed steps then random traffic.
module tb_rram_train_ctrl;

    localparam int N = 6;
    localparam int P = 4;
    localparam int G = 2;
    localparam int T = 5;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         set = 1'b0;
    logic         learn = 1'b0;
    logic         sample_valid = 1'b0;
    logic [N-1:0] sample_x = '0;
    logic         sample_label = 1'b0;
    logic         sample_ready;
    logic [N-1:0] Dwl, Dsl, Dbl;
    logic         Dset, Dback, Dlabel, busy, done;
    logic [7:0]   sample_cnt;

    int checks = 0;
    int errors = 0;

    rram_train_ctrl #(.N_ROWS(N), .PULSE_CYC(P), .GAP_CYC(G), .TRAIN_NUM(T)) dut (
        .clk(clk), .reset(reset), .set(set), .learn(learn),
        .sample_valid(sample_valid), .sample_x(sample_x), .sample_label(sample_label),
        .sample_ready(sample_ready), .Dwl(Dwl), .Dsl(Dsl), .Dbl(Dbl), .Dset(Dset),
        .Dback(Dback), .Dlabel(Dlabel), .busy(busy), .done(done), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] dwl, dsl, dbl;
        logic         dset, dback, dlabel, busy, done, ready;
        logic [7:0]   cnt;
    } frame_t;

    // Model: what is on the lines now, and the queue of frames already committed.
    typedef enum {M_IDLE, M_WAIT, M_Q} mdisp_t;
    mdisp_t  disp = M_IDLE;
    mdisp_t  after = M_IDLE;
    frame_t  q[$];
    int      mcnt = 0;
    frame_t  exp_f;

    function automatic frame_t mk(logic [N-1:0] wl, logic [N-1:0] sl, logic [N-1:0] bl,
                                  logic st, logic bk, logic lb, logic by, logic dn,
                                  logic rd, int c);
        frame_t f;
        f = {wl, sl, bl, st, bk, lb, by, dn, rd, 8'(c)};
        return f;
    endfunction

    function automatic frame_t observed();
        return {Dwl, Dsl, Dbl, Dset, Dback, Dlabel, busy, done, sample_ready, sample_cnt};
    endfunction

    task automatic model_edge();
        logic [N-1:0] oh;
        case (disp)
            M_IDLE: begin
                if (set) begin
                    for (int r = 0; r < N; r++) begin
                        oh = 1 << r;
                        repeat (P) q.push_back(mk(oh, '0, '1, 1, 0, 0, 1, 0, 0, mcnt));
                        repeat (G) q.push_back(mk('0, '0, '0, 0, 0, 0, 1, 0, 0, mcnt));
                    end
                    q.push_back(mk('0, '0, '0, 0, 0, 0, 0, 1, 0, mcnt));
                    after = M_IDLE;
                    disp  = M_Q;
                    exp_f = q.pop_front();
                end else if (learn) begin
                    mcnt  = 0;
                    disp  = M_WAIT;
                    exp_f = mk('0, '0, '0, 0, 0, 0, 1, 0, 1, mcnt);
                end else begin
                    exp_f = mk('0, '0, '0, 0, 0, 0, 0, 0, 0, mcnt);
                end
            end
            M_WAIT: begin
                if (sample_valid) begin
                    repeat (P) q.push_back(mk(sample_x, '1, '0, 0, 0, sample_label, 1, 0, 0, mcnt));
                    repeat (P) q.push_back(mk(sample_x, '0, sample_label ? sample_x : ~sample_x,
                                              0, 1, 0, 1, 0, 0, mcnt));
                    mcnt++;
                    repeat (G) q.push_back(mk('0, '0, '0, 0, 0, 0, 1, 0, 0, mcnt));
                    if (mcnt == T) begin
                        q.push_back(mk('0, '0, '0, 0, 0, 0, 0, 1, 0, mcnt));
                        after = M_IDLE;
                    end else begin
                        after = M_WAIT;
                    end
                    disp  = M_Q;
                    exp_f = q.pop_front();
                end else begin
                    exp_f = mk('0, '0, '0, 0, 0, 0, 1, 0, 1, mcnt);
                end
            end
            default: begin
                if (q.size() > 0) begin
                    exp_f = q.pop_front();
                end else begin
                    disp  = after;
                    exp_f = mk('0, '0, '0, 0, 0, 0, after == M_WAIT, 0, after == M_WAIT, mcnt);
                end
            end
        endcase
    endtask

    task automatic check(string tag, frame_t obs, frame_t expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick(string tag);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check(tag, observed(), exp_f);
        set   = 1'b0;
        learn = 1'b0;
    endtask

    initial begin
        int ok;
        frame_t zero_f;
        zero_f = '0;

        // reset held two cycles
        repeat (2) @(negedge clk);
        check("reset", observed(), zero_f);
        reset = 1'b1;
        tick("idle");

        // SET initialisation; done expected at cycle 37
        set = 1'b1;
        for (int c = 1; c <= 40; c++) tick("set_seq");

        // five samples x=101101 label=1, valid held high
        learn = 1'b1;
        sample_valid = 1'b1;
        sample_x = 6'b101101;
        sample_label = 1'b1;
        for (int c = 0; c < 70; c++) tick("learn_101101");

        // label 0 inverts bit lines during BACK
        learn = 1'b1;
        sample_x = 6'b000111;
        sample_label = 1'b0;
        for (int c = 0; c < 70; c++) tick("learn_000111");

        // stall valid for 20 cycles after learn
        learn = 1'b1;
        sample_valid = 1'b0;
        tick("stall_start");
        for (int c = 0; c < 20; c++) tick("stall");
        sample_valid = 1'b1;
        sample_x = 6'b110010;
        for (int c = 0; c < 60; c++) tick("stall_resume");
        sample_valid = 1'b0;

        // set and learn together, then learn during SET_PULSE
        set = 1'b1;
        learn = 1'b1;
        tick("set_learn");
        tick("set_learn");
        learn = 1'b1;
        for (int c = 0; c < 40; c++) tick("set_wins");

        // random traffic
        for (int c = 0; c < 600; c++) begin
            set          = ($urandom_range(0, 39) == 0);
            learn        = ($urandom_range(0, 19) == 0);
            sample_valid = ($urandom_range(0, 2) != 0);
            sample_x     = N'($urandom);
            sample_label = 1'($urandom);
            tick("random");
        end
        sample_valid = 1'b0;
        for (int c = 0; c < 80; c++) tick("drain");

        // async reset in the middle of BACK
        learn = 1'b1;
        sample_valid = 1'b1;
        sample_x = 6'b011011;
        sample_label = 1'b1;
        ok = 0;
        for (int c = 0; c < 40 && ok == 0; c++) begin
            tick("to_back");
            if (exp_f.dback) ok = 1;
        end
        checks++;
        assert (ok == 1) else begin
            errors++;
            $error("FAIL back_reached observed=%0d expected=1", ok);
        end
        tick("in_back");
        #2 reset = 1'b0;
        #1 check("async_reset", observed(), zero_f);
        q.delete();
        disp = M_IDLE;
        mcnt = 0;
        sample_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) tick("post_reset");
        learn = 1'b1;
        tick("post_reset_learn");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rram_train_ctrl.md
Name: rram_train_ctrl

Overview:
Array-drive sequencer for the 6-row RRAM crossbar. It sits directly downstream of the stimulus that issues clk/set/learn/reset. A `set` pulse runs a row-by-row SET initialisation of the array. A `learn` pulse runs TRAIN_NUM training samples, each as a forward (read) pulse and then a back (update) pulse. It produces the registered word-line, source-line and bit-line drive enables consumed by the analog array model.

Parameters:
N_ROWS, 6, number of word/source/bit lines driven
PULSE_CYC, 4, cycles each drive pulse is held (>=1)
GAP_CYC, 2, all-lines-low cycles after every pulse pair or SET row (>=1)
TRAIN_NUM, 5, samples consumed per learn command (1..255)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
set  in  1  one-cycle command: start SET initialisation
learn  in  1  one-cycle command: start training run
sample_valid  in  1  sample_x/sample_label valid
sample_x  in  N_ROWS  input pattern for current sample
sample_label  in  1  target label for current sample
sample_ready  out  1  controller can accept a sample
Dwl  out  N_ROWS  word-line enables
Dsl  out  N_ROWS  source-line enables
Dbl  out  N_ROWS  bit-line enables
Dset  out  1  SET phase active
Dback  out  1  back/update pulse active
Dlabel  out  1  label driven during forward pulse
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at end of a SET or learn sequence
sample_cnt  out  8  samples completed in current or last learn run

Behaviour:
- Reset (reset=0) forces all outputs to 0 immediately and sets the FSM to IDLE; counters clear. This includes reset in the middle of a sequence. All outputs are registered.
- States: IDLE, SET_PULSE, SET_GAP, WAIT_S, FWD, BACK, GAP, FIN.
- IDLE: busy=0. Commands are sampled on clk.
  - set=1 -> SET_PULSE, row=0.
  - Otherwise learn=1 -> WAIT_S, sample_cnt=0.
  - If set and learn are both 1 in the same cycle, set wins and learn is dropped.
  - Commands arriving while busy=1 are ignored, with no queueing.
- SET_PULSE: Dwl = one-hot(row), Dbl = all ones, Dset=1, Dsl=0, for PULSE_CYC cycles, then SET_GAP.
- SET_GAP: all lines 0, Dset=0, for GAP_CYC cycles. Then row+1 -> SET_PULSE if row < N_ROWS-1, else FIN.
- WAIT_S: sample_ready=1 and all lines 0. A transfer occurs on a cycle with sample_valid=1 and sample_ready=1; x and label are latched and the state goes to FWD. sample_ready is 0 in every other state.
- FWD (PULSE_CYC cycles): Dwl=x, Dsl=all ones, Dlabel=label, Dbl=0.
- BACK (PULSE_CYC cycles): Dback=1, Dwl=x, Dsl=0, Dlabel=0, Dbl = label ? x : ~x.
- GAP (GAP_CYC cycles): all lines 0, Dback=0. sample_cnt increments on entry.
  - Exit: sample_cnt==TRAIN_NUM -> FIN, else WAIT_S.
- FIN: done=1 for exactly one cycle, busy=0 in that same cycle, next state IDLE. A command presented during the FIN cycle is ignored.
- busy=1 in every state except IDLE and FIN.
- Latency, defaults, set sampled at cycle 0:
  - Dwl=000001 for cycles 1-4, lines 0 for cycles 5-6, Dwl=000010 from cycle 7.
  - Row 5 pulse covers cycles 31-34, gap 35-36, done at cycle 37.
- Learn timing, handshake at cycle t:
  - FWD t+1..t+P, BACK t+P+1..t+2P, GAP t+2P+1..t+2P+G.
  - Then sample_ready=1 at t+2P+G+1, or done at t+2P+G+1 after the last sample.
- sample_cnt holds its final value until the next learn command.
- A stalled sample_valid holds the FSM in WAIT_S indefinitely; no timeout.

Test Plan:
- Hold reset=0 for 2 cycles, then set=1 for 1 cycle -> Dwl one-hot walks 000001..100000 with Dset=1 for 4 cycles per row and 2-cycle gaps; done pulses at cycle 37; busy is 1 for cycles 1-36.
- Issue learn with sample_valid held high, x=101101, label=1 for all 5 samples:
  - FWD: Dwl=101101, Dsl=111111, Dlabel=1 for 4 cycles.
  - BACK: Dbl=101101, Dback=1 for 4 cycles.
  - Then a 2-cycle gap; sample_cnt=5 and done one cycle after the 5th gap.
- Sample with x=000111, label=0 -> Dbl=111000 during BACK.
- Stall sample_valid low for 20 cycles after learn -> sample_ready stays 1, all lines stay 0; progress resumes on the cycle after valid rises.
- set and learn asserted together, then learn asserted again during SET_PULSE -> only the SET sequence runs and sample_ready never rises.
- Assert reset=0 asynchronously mid-BACK -> all outputs 0 before the next clk edge; after release, FSM is in IDLE and sample_cnt=0.
